serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor that computes `a - b` LSB-first, one bit per clock. It uses a single full-subtractor cell and a registered borrow. It sits between operand-producing logic and downstream consumers, replacing a WIDTH-bit ripple subtractor where area matters more than latency. A start/busy/done handshake frames each operation, and result registers hold the last completed difference until the next operation finishes.

---
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first.
// Result registers hold the last difference until the next one completes.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-2:0] sd_q, sd_d;
   logic             bw_q, bw_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;

   logic             d_bit;
   logic             b_next;
   logic [WIDTH-1:0] sd_full;

   assign d_bit   = sa_q[0] ^ sb_q[0] ^ bw_q;
   assign b_next  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bw_q);
   // sd only keeps the upper WIDTH-1 bits; the newest bit completes the word
   assign sd_full = {d_bit, sd_q};

   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      sd_d     = sd_q;
      bw_d     = bw_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               sd_d    = '0;
               bw_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sa_d = sa_q >> 1;
            sb_d = sb_q >> 1;
            sd_d = sd_full[WIDTH-1:1];
            bw_d = b_next;
            if (cnt_q == LAST) begin
               diff_d   = sd_full;
               borrow_d = b_next;
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         sd_q     <= '0;
         bw_q     <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         sd_q     <= sd_d;
         bw_q     <= bw_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
      end
   end

   assign busy   = (state_q == S_SHIFT);
   assign done   = (state_q == S_DONE);
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8 directed, WIDTH=4 exhaustive).
// Stimulus pushes expected {borrow,diff}; monitors pop on each done pulse.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       busy, done, borrow;
   logic [7:0] diff;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, borrow4;
   logic [3:0] diff4;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int ndone   = 0;

   logic [8:0] q8[$];
   logic [4:0] q4[$];
   int         done_cyc[$];
   logic [8:0] last_res = '0;
   int         busy_run = 0;
   logic       prev_done = 1'b0;

   serial_subtractor #(.WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .borrow(borrow)
   );

   serial_subtractor #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input bit ok, input string name,
                      input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // WIDTH=8 monitor: result, busy length, done width, hold of result
   always @(negedge clk) begin
      if (!rst_n) begin
         last_res  = '0;
         busy_run  = 0;
         prev_done = 1'b0;
      end else begin
         if (busy) begin
            busy_run++;
            chk({borrow, diff} == last_res, "hold",
                32'({borrow, diff}), 32'(last_res));
         end
         if (done) begin
            ndone++;
            done_cyc.push_back(cyc);
            chk(busy_run == 8, "busy_len", busy_run, 8);
            chk(!prev_done, "done_width", 32'(prev_done), 0);
            if (q8.size() == 0) begin
               chk(1'b0, "unexpected_done", 32'({borrow, diff}), 0);
            end else begin
               last_res = q8.pop_front();
               chk({borrow, diff} == last_res, "result8",
                   32'({borrow, diff}), 32'(last_res));
            end
         end
         if (!busy) busy_run = 0;
         prev_done = done;
      end
   end

   always @(negedge clk) begin
      if (rst_n && done4) begin
         if (q4.size() == 0) begin
            chk(1'b0, "unexpected_done4", 32'({borrow4, diff4}), 0);
         end else begin
            logic [4:0] e;
            e = q4.pop_front();
            chk({borrow4, diff4} == e, "result4",
                32'({borrow4, diff4}), 32'(e));
         end
      end
   end

   task automatic wait_idle();
      int g = 0;
      @(negedge clk);
      while ((busy || done) && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) chk(1'b0, "timeout_idle", 32'(g), 200);
   endtask

   task automatic op(input logic [7:0] x, input logic [7:0] y);
      wait_idle();
      a = x;
      b = y;
      start = 1'b1;
      q8.push_back({1'b0, x} - {1'b0, y});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      @(negedge clk);
      while ((q8.size() != 0 || busy || done) && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (g >= 300) chk(1'b0, "timeout_drain", 32'(q8.size()), 0);
   endtask

   task automatic op4(input logic [3:0] x, input logic [3:0] y);
      int g = 0;
      @(negedge clk);
      while ((busy4 || done4) && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) chk(1'b0, "timeout_idle4", 32'(g), 50);
      a4 = x;
      b4 = y;
      start4 = 1'b1;
      q4.push_back({1'b0, x} - {1'b0, y});
      @(negedge clk);
      start4 = 1'b0;
   endtask

   initial begin
      int n0;
      int nb;
      int g;
      repeat (3) @(negedge clk);
      chk({busy, done, borrow, diff} == 0, "reset_state",
          32'({busy, done, borrow, diff}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk({busy, done, borrow, diff} == 0, "post_reset",
          32'({busy, done, borrow, diff}), 0);

      op(8'h05, 8'h03);
      op(8'h03, 8'h05);
      op(8'h00, 8'h01);
      op(8'hFF, 8'hFF);
      drain();

      // start re-pulsed mid-SHIFT must be ignored
      n0 = ndone;
      op(8'h80, 8'h01);
      repeat (2) @(negedge clk);
      a = 8'h00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();
      chk(ndone - n0 == 1, "single_done", 32'(ndone - n0), 1);
      nb = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy) nb++;
      end
      chk(nb == 0, "no_second_op", 32'(nb), 0);

      // start held high: back-to-back operations
      done_cyc.delete();
      wait_idle();
      a = 8'h0A;
      b = 8'h04;
      start = 1'b1;
      q8.push_back(9'h006);
      n0 = 1;
      g = 0;
      while (n0 < 3 && g < 100) begin
         @(negedge clk);
         g++;
         if (!busy && !done) begin
            q8.push_back(9'h006);
            n0++;
         end
      end
      @(negedge clk);
      start = 1'b0;
      drain();
      chk(done_cyc.size() == 3, "tput_count", 32'(done_cyc.size()), 3);
      if (done_cyc.size() == 3) begin
         chk(done_cyc[1] - done_cyc[0] == 10, "tput_period1",
             32'(done_cyc[1] - done_cyc[0]), 10);
         chk(done_cyc[2] - done_cyc[1] == 10, "tput_period2",
             32'(done_cyc[2] - done_cyc[1]), 10);
      end

      // reset during SHIFT cycle 4: outputs clear at once, no done
      n0 = ndone;
      wait_idle();
      a = 8'h55;
      b = 8'h22;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1 chk({busy, done, borrow, diff} == 0, "async_reset",
             32'({busy, done, borrow, diff}), 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk(ndone == n0, "no_done_after_reset", 32'(ndone - n0), 0);
      op(8'h10, 8'h01);
      drain();

      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            op4(4'(i), 4'(j));
         end
      end
      g = 0;
      while ((q4.size() != 0 || busy4 || done4) && g < 50) begin
         @(negedge clk);
         g++;
      end

      chk(q8.size() == 0, "queue8_empty", 32'(q8.size()), 0);
      chk(q4.size() == 0, "queue4_empty", 32'(q4.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
